// File: rtl/gmii_pkg.sv
// gmii_pkg: shared definitions for the GMII transmit/receive MAC blocks.
//   - c_code stream tags (SOP/MOD/EOP/EOP_ERR)
//   - preamble / start-of-frame delimiter bytes
//   - CRC-32 polynomial (normal and reflected) and initial value
//   - transmit framer state encoding
package gmii_pkg;

    localparam logic [1:0] SOP     = 2'd0;
    localparam logic [1:0] MOD     = 2'd1;
    localparam logic [1:0] EOP     = 2'd2;
    localparam logic [1:0] EOP_ERR = 2'd3;

    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam logic [7:0] SFD      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_FLUSH
    } tx_state_t;

endpackage

// File: rtl/gmii_crc32.sv
// gmii_crc32: byte-wide combinational CRC-32 next-state function.
// Uses the reflected (LSB-first) form, so bit 0 of each byte is the first
// bit on the wire. The register value is un-inverted; the FCS is ~crc_out
// once all bytes have been folded in.
//   data    [7:0]  : byte to fold into the CRC
//   crc_in  [31:0] : current CRC register
//   crc_out [31:0] : CRC register after absorbing data
module gmii_crc32
    import gmii_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_tx_mac.sv
// gmii_tx_mac: transmit-side GMII framer.
// Takes packets from an srdy/drdy byte stream, prepends preamble + SFD,
// zero-pads short frames, appends the CRC-32 FCS and holds the inter-frame
// gap before the next frame.
//   clk          : 125 MHz stream / GMII clock
//   reset_n      : asynchronous active-low reset
//   c_srdy       : source presents a byte
//   c_drdy       : block accepts the byte this cycle (combinational)
//   c_code [1:0] : SOP / MOD / EOP / EOP_ERR tag of the byte
//   c_data [7:0] : payload byte
//   gmii_tx_en   : frame valid on the wire
//   gmii_txd     : wire data
//   gmii_tx_er   : error propagation to the PHY
//   tx_done      : pulse with the last FCS byte on the wire
//   tx_underrun  : pulse with the abort (tx_er) cycle on the wire
module gmii_tx_mac
    import gmii_pkg::*;
#(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_DATA   = 60,
    parameter bit PAD_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       c_srdy,
    output logic       c_drdy,
    input  logic [1:0] c_code,
    input  logic [7:0] c_data,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_er,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
    localparam logic [15:0] MIN_CNT  = 16'(MIN_DATA);
    localparam logic [15:0] PRE_LAST = 16'd6;
    localparam logic [15:0] FCS_LAST = 16'd3;

    tx_state_t   state;
    logic [15:0] cyc_cnt;
    logic [15:0] byte_cnt;
    logic [15:0] byte_inc;
    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic [7:0]  crc_byte;
    logic        err_q;
    logic        first_byte;
    logic        is_eop;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The FCS goes out least-significant byte first; the reflected CRC
    // already has the wire bit order inside each byte.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] f;
        f = ~crc;
        case (idx)
            2'd0:    return f[7:0];
            2'd1:    return f[15:8];
            2'd2:    return f[23:16];
            default: return f[31:24];
        endcase
    endfunction

    assign byte_inc   = sat_inc16(byte_cnt);
    assign first_byte = (byte_cnt == 16'd0);
    assign is_eop     = (c_code == EOP) || (c_code == EOP_ERR);
    assign crc_byte   = (state == ST_PAD) ? 8'h00 : c_data;

    gmii_crc32 u_crc (
        .data    (crc_byte),
        .crc_in  (crc_q),
        .crc_out (crc_next)
    );

    // In DATA the first byte is the SOP that opened the frame; any later
    // SOP belongs to the next frame and must stay with the source.
    always_comb begin
        c_drdy = 1'b0;
        case (state)
            ST_IDLE:  c_drdy = c_srdy && (c_code != SOP);
            ST_DATA:  c_drdy = first_byte || (c_code != SOP);
            ST_FLUSH: c_drdy = 1'b1;
            ST_IFG:   if (cyc_cnt == IFG_LAST) c_drdy = c_srdy && (c_code != SOP);
            default:  c_drdy = 1'b0;
        endcase
        if (!reset_n) c_drdy = 1'b0;
    end

    // Registered wire stage: outputs show the state decoded one cycle earlier
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cyc_cnt     <= 16'd0;
            byte_cnt    <= 16'd0;
            crc_q       <= CRC_INIT;
            err_q       <= 1'b0;
            gmii_tx_en  <= 1'b0;
            gmii_txd    <= 8'h00;
            gmii_tx_er  <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            gmii_tx_en  <= 1'b0;
            gmii_txd    <= 8'h00;
            gmii_tx_er  <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (c_srdy && (c_code == SOP)) begin
                        state   <= ST_PRE;
                        cyc_cnt <= 16'd0;
                    end
                end
                ST_PRE: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= PREAMBLE;
                    if (cyc_cnt == PRE_LAST) state <= ST_SFD;
                    else cyc_cnt <= cyc_cnt + 16'd1;
                end
                ST_SFD: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= SFD;
                    crc_q      <= CRC_INIT;
                    byte_cnt   <= 16'd0;
                    err_q      <= 1'b0;
                    state      <= ST_DATA;
                end
                ST_DATA: begin
                    gmii_tx_en <= 1'b1;
                    if (!c_srdy || (!first_byte && (c_code == SOP))) begin
                        // Abort: one tx_er cycle marks the frame bad at the PHY.
                        // A starved source is drained in FLUSH; an early SOP
                        // means the old frame is gone, so wait out the gap.
                        gmii_tx_er  <= 1'b1;
                        tx_underrun <= 1'b1;
                        cyc_cnt     <= 16'd0;
                        state       <= c_srdy ? ST_IFG : ST_FLUSH;
                    end else begin
                        gmii_txd <= c_data;
                        crc_q    <= crc_next;
                        byte_cnt <= byte_inc;
                        if (!first_byte && is_eop) begin
                            err_q   <= (c_code == EOP_ERR);
                            cyc_cnt <= 16'd0;
                            state   <= (PAD_EN && (byte_inc < MIN_CNT)) ? ST_PAD : ST_FCS;
                        end
                    end
                end
                ST_PAD: begin
                    gmii_tx_en <= 1'b1;
                    crc_q      <= crc_next;
                    byte_cnt   <= byte_inc;
                    if (byte_inc >= MIN_CNT) begin
                        cyc_cnt <= 16'd0;
                        state   <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= fcs_byte(crc_q, cyc_cnt[1:0]);
                    gmii_tx_er <= err_q;
                    if (cyc_cnt == FCS_LAST) begin
                        tx_done <= 1'b1;
                        cyc_cnt <= 16'd0;
                        state   <= ST_IFG;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                ST_IFG: begin
                    if (cyc_cnt == IFG_LAST) begin
                        cyc_cnt <= 16'd0;
                        state   <= (c_srdy && (c_code == SOP)) ? ST_PRE : ST_IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                ST_FLUSH: begin
                    if (c_srdy && is_eop) begin
                        cyc_cnt <= 16'd0;
                        state   <= ST_IFG;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/gmii_tx_mac.md
# gmii_tx_mac

Transmit-side GMII MAC framer: the byte-stream counterpart to the GMII receive path feeding the bridge. It takes packets from an srdy/drdy byte stream and drives `gmii_tx_en`/`gmii_txd`/`gmii_tx_er`. It inserts preamble and SFD, pads short frames, appends the CRC-32 FCS and enforces the inter-frame gap. It sits at each bridge egress port, directly in front of the PHY (or the bench GMII monitor).

## Interface
- `IFG_CYCLES`, default 12: minimum idle cycles on the wire between frames (≥4).
- `MIN_DATA`, default 60: minimum pre-FCS byte count; shorter frames are zero-padded.
- `PAD_EN`, default 1: 1 enables padding, 0 disables it.
- `clk`, input, 1: single clock for the stream and GMII (125 MHz).
- `reset_n`, input, 1: reset, **asynchronous, active-low**.
- `c_srdy`, input, 1: source has a valid byte.
- `c_drdy`, output, 1: block accepts the byte this cycle. Transfer occurs when `c_srdy & c_drdy`.
- `c_code`, input, 2: `SOP`=0, `MOD`=1, `EOP`=2, `EOP_ERR`=3.
- `c_data`, input, 8: payload byte.
- `gmii_tx_en`, output, 1: frame valid on wire.
- `gmii_txd`, output, 8: wire data.
- `gmii_tx_er`, output, 1: error propagation to PHY.
- `tx_done`, output, 1: one-cycle pulse when the last FCS byte is on the wire.
- `tx_underrun`, output, 1: one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, FLUSH.
- **IDLE**
  - `c_drdy` = `c_srdy & (c_code != SOP)`: stray non-SOP bytes are discarded silently.
  - A SOP byte with `c_srdy` is not consumed. The state moves to PRE.
- **PRE**: 7 cycles. **SFD**: 1 cycle.
- **DATA**
  - `c_drdy` = 1. One byte is consumed per cycle, starting with the SOP byte.
  - A 16-bit saturating byte counter increments on each transfer.
  - A CRC register is initialised to 0xFFFFFFFF at SFD and updated on every data and pad byte.
- **End of data (EOP or EOP_ERR accepted)**
  - If `PAD_EN` and count < `MIN_DATA`, go to PAD. PAD emits 0x00 until count = `MIN_DATA`.
  - Otherwise go to FCS.
- **FCS**
  - 4 cycles emitting ~CRC, least-significant byte first, bit-reflected per IEEE 802.3.
  - For EOP_ERR, `gmii_tx_er`=1 during all 4 FCS cycles.
  - Then go to IFG.
- **IFG**
  - Lasts `IFG_CYCLES` cycles with `c_drdy`=0.
  - On the last IFG cycle, a pending SOP is evaluated exactly as in IDLE and the state goes directly to PRE. Otherwise go to IDLE.
- **Underrun** (`c_srdy`=0 in DATA)
  - `gmii_tx_er`=1 with `gmii_tx_en`=1 for one wire cycle.
  - `tx_underrun` pulses.
  - State goes to FLUSH.
- **FLUSH**: `c_drdy`=1, discarding until EOP/EOP_ERR is accepted, then IFG.
- **SOP received in DATA**: handled as an underrun, except the SOP byte is not consumed and FLUSH is skipped (straight to IFG).
- `MOD`/`EOP` in IDLE are discarded. A frame must contain at least 2 bytes (SOP + EOP).

## Timing
- All GMII outputs and `tx_done`/`tx_underrun` are registered. The wire shows the state decoded one cycle earlier. `c_drdy` is combinational from state, `c_srdy` and `c_code`.
- **Reset**
  - Asynchronous assertion forces state IDLE.
  - All outputs reset to 0: `gmii_tx_en`, `gmii_txd`=0x00, `gmii_tx_er`, `tx_done`, `tx_underrun`, `c_drdy`.
  - CRC resets to 0xFFFFFFFF and counters to 0.
  - Reset mid-frame truncates the wire frame immediately. No FCS is emitted. The partial input frame is not flushed.
- **Latency**, for SOP presented in IDLE at cycle T:
  - First 0x55 on the wire at T+2.
  - SFD at T+9.
  - Data byte 0 at T+10.
- Wire `tx_en` length = 8 + max(N, `MIN_DATA` if padding) + 4, where N is the input byte count.
- Back-to-back frames (SOP pending): `tx_en` is low for exactly `IFG_CYCLES` cycles between frames.
- `tx_done` coincides with the 4th FCS byte on the wire. `tx_underrun` coincides with the `tx_er` cycle.

## Structure
- Shared package `gmii_pkg` holds:
  - the `c_code` constants SOP/MOD/EOP/EOP_ERR;
  - `PREAMBLE`=8'h55, `SFD`=8'hD5;
  - CRC polynomial 32'h04C11DB7 (reflected form 32'hEDB88320) and init value;
  - the state encoding.
- One sub-module, `gmii_crc32`: byte-wide combinational next-CRC function (8-bit data, 32-bit CRC in, 32-bit CRC out). The receive-side checker reuses it.

## Test plan
- **Full-size frame**: 60 bytes 0x00..0x3B (SOP, 58×MOD, EOP), `c_srdy` held high. Expect:
  - `tx_en` high for 72 cycles: 7×55, D5, 60 data, 4 FCS.
  - FCS matches the reference CRC model.
  - `tx_done` pulses once.
- **Short frame with padding**: 14 bytes with `PAD_EN`=1. Expect 46 bytes of 0x00 appended, FCS computed over the padded 60 bytes, `tx_en` for 72 cycles.
- **Known CRC vector**: `PAD_EN`=0, ASCII "123456789". Expect FCS on the wire 26 39 F4 CB, and `tx_en` for 21 cycles.
- **Back-to-back frames**: two 64-byte frames with `c_srdy` continuous. Expect exactly 12 low `tx_en` cycles between frames, and the second preamble 2 cycles after its SOP is presented in the final IFG cycle.
- **Underrun**: `c_srdy` dropped for 1 cycle after byte 20 of 60. Expect:
  - one `tx_en`=1/`tx_er`=1 cycle and a `tx_underrun` pulse;
  - remaining input bytes drained with `tx_en`=0;
  - the next frame is correct.
- **EOP_ERR and reset**:
  - A frame ending in EOP_ERR gives `tx_er`=1 during the 4 FCS cycles.
  - `reset_n` asserted mid-DATA gives `tx_en`=`txd`=`tx_er`=0 immediately, with no clock edge.
  - After release, a clean 60-byte frame passes.
